// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs decoded instruction fields arriving on a valid/ready stream into
// 32-bit instruction words and writes them sequentially into instruction
// memory, starting at a base address captured on start. Used to load a
// program before the processor is released.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, base_addr           open a load session at base_addr
//   in_valid/in_ready          field stream handshake
//   in_opcode..in_imm, in_last decoded fields, in_last closes the session
//   mem_we/mem_addr/mem_wdata  memory write request, held until mem_ready
//   mem_ready                  memory accepts the write this cycle
//   busy, done                 session running / session finished
//   err_opcode, err_overflow   sticky per-session error flags
//   instr_count                words written in the current session
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | accepting beats and writing words
// DONE   | session finished, results held until next start
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [5:0]        in_func,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_opcode,
  output logic              err_overflow,
  output logic [ADDR_W:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              pend_last_q, pend_last_d;
  logic              last_acc_q, last_acc_d;
  logic              err_op_q, err_op_d;
  logic              err_ovf_q, err_ovf_d;

  logic              legal;
  logic              wr_done;
  logic              accept;
  logic [31:0]       enc_word;
  logic [ADDR_W+1:0] occupancy;
  logic [ADDR_W+1:0] cnt_next_w;

  assign legal   = (in_opcode <= 6'd8);
  assign wr_done = we_q && mem_ready;
  assign accept  = in_valid && in_ready;

  // Words already written plus the one in the output register; a new beat
  // is only taken if it still fits inside the session budget.
  assign occupancy  = {1'b0, cnt_q} + {{(ADDR_W+1){1'b0}}, we_q};
  assign cnt_next_w = {1'b0, cnt_q} + {{(ADDR_W+1){1'b0}}, 1'b1};

  assign in_ready = (state_q == S_RUN) && (!we_q || mem_ready) &&
                    !last_acc_q && (occupancy < DEPTH_L);

  always_comb begin
    enc_word = {in_opcode, in_rd, in_rs1, in_imm[15:0]};
    if (in_opcode == 6'd0) begin
      enc_word = {in_opcode, in_rd, in_rs1, in_rs2, 5'b0, in_func};
    end else if (in_opcode == 6'd5) begin
      enc_word = {in_opcode, in_imm};
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    pend_last_d = pend_last_q;
    last_acc_d  = last_acc_q;
    err_op_d    = err_op_q;
    err_ovf_d   = err_ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          addr_d      = base_addr;
          cnt_d       = '0;
          we_d        = 1'b0;
          pend_last_d = 1'b0;
          last_acc_d  = 1'b0;
          err_op_d    = 1'b0;
          err_ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (wr_done) begin
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_d  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          we_d   = 1'b0;
          if (pend_last_q) begin
            state_d = S_DONE;
          end else if (cnt_next_w == DEPTH_L) begin
            state_d   = S_DONE;
            err_ovf_d = 1'b1;
          end
        end
        // A beat can only be accepted when the output register is free or
        // draining this cycle, so overwriting it here never loses a word.
        if (accept) begin
          if (legal) begin
            we_d        = 1'b1;
            wdata_d     = enc_word;
            pend_last_d = in_last;
          end else begin
            err_op_d = 1'b1;
            if (in_last) begin
              state_d = S_DONE;
            end
          end
          if (in_last) begin
            last_acc_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      pend_last_q <= 1'b0;
      last_acc_q  <= 1'b0;
      err_op_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      pend_last_q <= pend_last_d;
      last_acc_q  <= last_acc_d;
      err_op_q    <= err_op_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign err_opcode   = err_op_q;
  assign err_overflow = err_ovf_q;
  assign instr_count  = cnt_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields over a valid/ready stream and packs them into 32-bit instruction words.
- Writes the packed words sequentially into instruction memory, starting at a programmable base address.
- Sits between the test/boot program source and the instruction memory write port. Used to load programs before the processor runs.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, maximum number of words per load session (1..2^ADDR_W)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; opens a load session
base_addr  input  ADDR_W  first write address, sampled on start
in_valid  input  1  instruction fields valid
in_ready  output  1  block accepts fields this cycle
in_opcode  input  6  opcode (0..8 legal)
in_rd  input  5  destination register (R3 field)
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2 (R-type only)
in_func  input  6  function code (R-type only)
in_imm  input  26  immediate; [15:0] for I-class, [25:0] for J-type
in_last  input  1  marks final instruction of the session
mem_we  output  1  write request to instruction memory
mem_addr  output  ADDR_W  write address
mem_wdata  output  32  encoded instruction word
mem_ready  input  1  memory accepts the write when mem_we && mem_ready
busy  output  1  high in RUN state
done  output  1  high in DONE state
err_opcode  output  1  sticky: an illegal opcode was accepted
err_overflow  output  1  sticky: DEPTH words written before in_last
instr_count  output  ADDR_W+1  words written in current session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; address counter 0.
- FSM states and transitions:
  - IDLE -> RUN on start. Loads the address counter from base_addr; clears instr_count and both error flags.
  - RUN -> DONE in any of three cases:
    - the write of the in_last word completes;
    - an in_last beat with an illegal opcode is accepted (DONE on the next cycle);
    - instr_count reaches DEPTH with no in_last seen. err_overflow is set in this case.
  - DONE -> RUN on start, with the same initialisation as from IDLE.
  - start while in RUN is ignored.
- Encoding, by opcode:
  - opcode 0 (R-type): {opcode, rd, rs1, rs2, 5'b0, func}.
  - opcodes 1-4, 6, 7, 8 (add/sub/mul/nand-imm, beq, load, store): {opcode, rd, rs1, imm[15:0]}.
  - opcode 5 (J-type): {opcode, imm[25:0]}.
  - Unused input fields are ignored.
- Illegal opcode (9..63):
  - the beat is accepted and dropped, with no write;
  - err_opcode is set;
  - instr_count and the address counter are unchanged.
- Pipeline: one output register.
  - A beat accepted in cycle N drives mem_we/mem_addr/mem_wdata in cycle N+1.
  - mem_addr/mem_wdata hold stable while mem_we=1 and mem_ready=0.
- in_ready = RUN && (!mem_we || mem_ready) && !last_accepted && (instr_count + pending < DEPTH).
  - Back-to-back writes at full rate are supported when mem_ready stays high.
- On a write completing: the address counter increments and instr_count increments.
  - The address wraps modulo 2^ADDR_W.
  - Wrap alone is not an error.
- After in_last is accepted, in_ready stays 0 until the session ends.
- Reset mid-session aborts immediately. Any pending write is discarded; mem_we drops asynchronously.

Test Plan:
1. R-type: start, base=0x10; opcode=0, rd=3, rs1=1, rs2=2, func=1, last=1 -> one write at 0x10 of 0x00611001 one cycle after accept; done=1; instr_count=1.
2. Mixed stream with mem_ready=1:
   - I-add opcode=1, rd=5, rs1=6, imm=0xFFFF -> 0x04A6FFFF at base;
   - J opcode=5, imm=0x3FFFFFF -> 0x17FFFFFF at base+1;
   - store opcode=8, rd=2, rs1=4, imm=0x0010, last=1 -> 0x20440010 at base+2;
   - 3 consecutive cycles of mem_we.
3. Backpressure: hold mem_ready=0 for 3 cycles during the test 2 stream -> mem_addr/mem_wdata stable, in_ready=0, no beat lost; words and order match test 2.
4. Illegal opcode: opcode=9 mid-stream -> no write, err_opcode=1 sticky, next legal word written at the next address (no gap).
5. Overflow: DEPTH=4, send 5 beats without last -> 4 writes; in_ready stays 0 after the 4th accept; err_overflow=1; DONE.
6. Restart and reset: start in DONE clears count and errors and reloads base. rst_n low while mem_we=1 and mem_ready=0 -> all outputs 0 immediately; no write after release.
